// File: rtl/packet_router_1x3_pkg.sv
// Shared constants and FSM state type
// for the 1x3 byte-stream packet router.
package packet_router_1x3_pkg;

  localparam int DATA_W     = 8;
  localparam int FIFO_DEPTH = 16;
  localparam int TIMEOUT    = 30;

  localparam logic [1:0] PORT0        = 2'd0;
  localparam logic [1:0] PORT1        = 2'd1;
  localparam logic [1:0] PORT2        = 2'd2;
  localparam logic [1:0] ADDR_INVALID = 2'd3;

  typedef enum logic [2:0] {
    DECODE_ADDRESS,
    WAIT_TILL_EMPTY,
    LOAD_FIRST_DATA,
    LOAD_DATA,
    FIFO_FULL_STATE,
    LOAD_AFTER_FULL,
    LOAD_PARITY,
    CHECK_PARITY_ERROR
  } state_e;

endpackage

// File: rtl/router_fifo.sv
// Output-port FIFO with registered read data
// and an unread-data timeout flush.
module router_fifo
  import packet_router_1x3_pkg::*;
#(
  parameter int DEPTH = FIFO_DEPTH,
  parameter int W     = DATA_W,
  parameter int TMO   = TIMEOUT
) (
  input  logic         clock,
  input  logic         resetn,
  input  logic         we,
  input  logic         re,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         empty,
  output logic         full,
  output logic         flush
);

  localparam int AW = $clog2(DEPTH);
  localparam int TW = $clog2(TMO + 1);
  localparam logic [AW:0] P_ONE = 1;
  localparam logic [TW-1:0] T_ONE = 1;
  localparam logic [TW-1:0] T_LAST = TW'(TMO - 1);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW:0]   wp_q, wp_d;
  logic [AW:0]   rp_q, rp_d;
  logic [W-1:0]  dout_q, dout_d;
  logic [TW-1:0] cnt_q, cnt_d;
  logic          do_wr, do_rd, idle;

  assign empty = (wp_q == rp_q);
  assign full  = (wp_q[AW] != rp_q[AW]) &&
                 (wp_q[AW-1:0] == rp_q[AW-1:0]);
  assign idle  = !empty && !re;
  assign flush = idle && (cnt_q == T_LAST);
  assign do_wr = we && !full && !flush;
  assign do_rd = re && !empty;
  assign dout  = dout_q;

  // Pointer, read-data and idle-counter next state
  always_comb begin
    wp_d   = wp_q;
    rp_d   = rp_q;
    dout_d = dout_q;
    cnt_d  = '0;
    if (do_wr) wp_d = wp_q + P_ONE;
    if (do_rd) begin
      rp_d   = rp_q + P_ONE;
      dout_d = mem_q[rp_q[AW-1:0]];
    end
    if (idle && !flush) cnt_d = cnt_q + T_ONE;
    if (flush) begin
      wp_d = '0;
      rp_d = '0;
    end
  end

  // Storage array, contents qualified by pointers
  always_ff @(posedge clock) begin
    if (do_wr) mem_q[wp_q[AW-1:0]] <= din;
  end

  // Control registers
  always_ff @(posedge clock) begin
    if (resetn) begin
      wp_q   <= '0;
      rp_q   <= '0;
      dout_q <= '0;
      cnt_q  <= '0;
    end else begin
      wp_q   <= wp_d;
      rp_q   <= rp_d;
      dout_q <= dout_d;
      cnt_q  <= cnt_d;
    end
  end

endmodule

// File: rtl/packet_router_1x3.sv
// 1x3 packet router: header decode, parity
// check and steering into three port FIFOs.
module packet_router_1x3
  import packet_router_1x3_pkg::*;
(
  input  logic       clock,
  input  logic       resetn,
  input  logic       pkt_valid,
  input  logic       read_enb_0,
  input  logic       read_enb_1,
  input  logic       read_enb_2,
  input  logic [7:0] data_in,
  output logic [7:0] data_out_0,
  output logic [7:0] data_out_1,
  output logic [7:0] data_out_2,
  output logic       vld_out_0,
  output logic       vld_out_1,
  output logic       vld_out_2,
  output logic       err,
  output logic       busy
);

  state_e     state_q, state_d;
  logic [1:0] addr_q, addr_d;
  logic [7:0] hdr_q, hdr_d;
  logic [7:0] hold_q, hold_d;
  logic [7:0] par_q, par_d;
  logic [7:0] rxp_q, rxp_d;
  logic       err_q, err_d;
  logic       drop_q, drop_d;
  logic       we;
  logic [7:0] wdata;
  logic [2:0] wen;
  logic [3:0] empty, full, flush;

  assign empty[3] = 1'b1;
  assign full[3]  = 1'b0;
  assign flush[3] = 1'b0;

  assign wen[0] = we && (addr_q == PORT0);
  assign wen[1] = we && (addr_q == PORT1);
  assign wen[2] = we && (addr_q == PORT2);

  assign vld_out_0 = !empty[0];
  assign vld_out_1 = !empty[1];
  assign vld_out_2 = !empty[2];
  assign err       = err_q;

  router_fifo u_fifo0 (
    .clock (clock),      .resetn (resetn),
    .we    (wen[0]),     .re     (read_enb_0),
    .din   (wdata),      .dout   (data_out_0),
    .empty (empty[0]),   .full   (full[0]),
    .flush (flush[0])
  );

  router_fifo u_fifo1 (
    .clock (clock),      .resetn (resetn),
    .we    (wen[1]),     .re     (read_enb_1),
    .din   (wdata),      .dout   (data_out_1),
    .empty (empty[1]),   .full   (full[1]),
    .flush (flush[1])
  );

  router_fifo u_fifo2 (
    .clock (clock),      .resetn (resetn),
    .we    (wen[2]),     .re     (read_enb_2),
    .din   (wdata),      .dout   (data_out_2),
    .empty (empty[2]),   .full   (full[2]),
    .flush (flush[2])
  );

  // Packet FSM: decode, load, parity, abort on flush
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    hdr_d   = hdr_q;
    hold_d  = hold_q;
    par_d   = par_q;
    rxp_d   = rxp_q;
    err_d   = err_q;
    drop_d  = drop_q;
    we      = 1'b0;
    wdata   = hold_q;
    busy    = 1'b1;
    unique case (state_q)
      DECODE_ADDRESS: begin
        busy = 1'b0;
        if (drop_q) begin
          if (!pkt_valid) drop_d = 1'b0;
        end else if (pkt_valid) begin
          if (data_in[1:0] == ADDR_INVALID) begin
            drop_d = 1'b1;
          end else begin
            addr_d  = data_in[1:0];
            hdr_d   = data_in;
            par_d   = data_in;
            err_d   = 1'b0;
            state_d = empty[data_in[1:0]] ?
                      LOAD_FIRST_DATA : WAIT_TILL_EMPTY;
          end
        end
      end
      WAIT_TILL_EMPTY: begin
        if (empty[addr_q]) state_d = LOAD_FIRST_DATA;
      end
      LOAD_FIRST_DATA: begin
        we      = 1'b1;
        wdata   = hdr_q;
        state_d = LOAD_DATA;
      end
      LOAD_DATA: begin
        busy = 1'b0;
        if (pkt_valid) begin
          par_d = par_q ^ data_in;
          if (full[addr_q]) begin
            hold_d  = data_in;
            state_d = FIFO_FULL_STATE;
          end else begin
            we    = 1'b1;
            wdata = data_in;
          end
        end else begin
          rxp_d   = data_in;
          state_d = LOAD_PARITY;
        end
      end
      FIFO_FULL_STATE: begin
        if (!full[addr_q]) state_d = LOAD_AFTER_FULL;
      end
      LOAD_AFTER_FULL: begin
        we = 1'b1;
        if (pkt_valid) begin
          state_d = LOAD_DATA;
        end else begin
          rxp_d   = data_in;
          state_d = LOAD_PARITY;
        end
      end
      LOAD_PARITY: begin
        if (!full[addr_q]) begin
          we      = 1'b1;
          wdata   = rxp_q;
          state_d = CHECK_PARITY_ERROR;
        end
      end
      CHECK_PARITY_ERROR: begin
        err_d   = (par_q != rxp_q);
        state_d = DECODE_ADDRESS;
      end
      default: state_d = DECODE_ADDRESS;
    endcase
    // A flushed target kills the packet in flight;
    // any payload still to come is swallowed.
    if (flush[addr_q]) begin
      unique case (state_q)
        LOAD_FIRST_DATA,
        FIFO_FULL_STATE,
        LOAD_AFTER_FULL: begin
          state_d = DECODE_ADDRESS;
          drop_d  = 1'b1;
        end
        LOAD_DATA: begin
          state_d = DECODE_ADDRESS;
          drop_d  = pkt_valid;
        end
        LOAD_PARITY: state_d = DECODE_ADDRESS;
        default: ;
      endcase
    end
  end

  // FSM and datapath registers
  always_ff @(posedge clock) begin
    if (resetn) begin
      state_q <= DECODE_ADDRESS;
      addr_q  <= '0;
      hdr_q   <= '0;
      hold_q  <= '0;
      par_q   <= '0;
      rxp_q   <= '0;
      err_q   <= 1'b0;
      drop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      hdr_q   <= hdr_d;
      hold_q  <= hold_d;
      par_q   <= par_d;
      rxp_q   <= rxp_d;
      err_q   <= err_d;
      drop_q  <= drop_d;
    end
  end

endmodule

// File: tb/tb_packet_router_1x3.sv
// Directed + random bench for packet_router_1x3
// against a packet-level queue model.
module tb_packet_router_1x3;
  import packet_router_1x3_pkg::*;

  typedef logic [7:0] bq_t [$];

  logic       clock = 1'b0;
  logic       resetn = 1'b1;
  logic       pkt_valid = 1'b0;
  logic       read_enb_0 = 1'b0;
  logic       read_enb_1 = 1'b0;
  logic       read_enb_2 = 1'b0;
  logic [7:0] data_in = '0;
  logic [7:0] data_out_0, data_out_1, data_out_2;
  logic       vld_out_0, vld_out_1, vld_out_2;
  logic       err, busy;

  int   vectors = 0;
  int   miscompares = 0;
  int   cyc = 0;
  int   rise_c = -1;
  int   fall_c = -1;
  logic vld0_d = 1'b0;
  logic abort_drv = 1'b0;
  logic [2:0] rdp = '0;
  logic exp_err;
  bq_t  got [3];
  bq_t  exp_q [3];

  packet_router_1x3 dut (
    .clock      (clock),
    .resetn     (resetn),
    .pkt_valid  (pkt_valid),
    .read_enb_0 (read_enb_0),
    .read_enb_1 (read_enb_1),
    .read_enb_2 (read_enb_2),
    .data_in    (data_in),
    .data_out_0 (data_out_0),
    .data_out_1 (data_out_1),
    .data_out_2 (data_out_2),
    .vld_out_0  (vld_out_0),
    .vld_out_1  (vld_out_1),
    .vld_out_2  (vld_out_2),
    .err        (err),
    .busy       (busy)
  );

  always #5 clock = ~clock;

  always @(posedge clock) begin
    cyc <= cyc + 1;
    rdp <= {read_enb_2 & vld_out_2,
            read_enb_1 & vld_out_1,
            read_enb_0 & vld_out_0};
  end

  // Collect every byte delivered by a read
  always @(negedge clock) begin
    if (rdp[0]) got[0].push_back(data_out_0);
    if (rdp[1]) got[1].push_back(data_out_1);
    if (rdp[2]) got[2].push_back(data_out_2);
    if (vld_out_0 && !vld0_d) rise_c = cyc;
    if (!vld_out_0 && vld0_d) fall_c = cyc;
    vld0_d = vld_out_0;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not end");
    $fatal(1);
  end

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  function automatic logic vld_of(input int p);
    case (p)
      0: return vld_out_0;
      1: return vld_out_1;
      default: return vld_out_2;
    endcase
  endfunction

  // Packet model: header, random payload, XOR parity
  function automatic bq_t make_pkt(input logic [1:0] a,
                                   input int len,
                                   input bit bad);
    bq_t q;
    logic [7:0] h, par, b;
    h = {6'(len), a};
    q.push_back(h);
    par = h;
    for (int i = 0; i < len; i++) begin
      b = 8'($urandom);
      q.push_back(b);
      par ^= b;
    end
    q.push_back(bad ? ~par : par);
    return q;
  endfunction

  task automatic cycles(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic set_rd(input logic [2:0] m);
    {read_enb_2, read_enb_1, read_enb_0} = m;
  endtask

  task automatic do_reset();
    resetn = 1'b1;
    pkt_valid = 1'b0;
    data_in = '0;
    set_rd(3'b000);
    cycles(2);
    resetn = 1'b0;
    cycles(1);
    for (int p = 0; p < 3; p++) begin
      got[p].delete();
      exp_q[p].delete();
    end
  endtask

  // Source: each byte held until sampled with busy=0
  task automatic send(input bq_t b);
    int n;
    for (int i = 0; i < b.size(); i++) begin
      data_in = b[i];
      pkt_valid = (i != b.size() - 1);
      n = 0;
      while (busy && !abort_drv && n < 200) begin
        @(negedge clock);
        n++;
      end
      if (abort_drv) return;
      if (n >= 200) begin
        check("send_stall", 1, 0);
        return;
      end
      @(negedge clock);
    end
    pkt_valid = 1'b0;
    data_in = '0;
  endtask

  task automatic drain(input int p);
    int n;
    n = 0;
    while (vld_of(p) && n < 100) begin
      @(negedge clock);
      n++;
    end
    check("drain_bound", n >= 100, 0);
    @(negedge clock);
  endtask

  task automatic cmp_port(input int p, input string tag);
    check({tag, "_len"}, got[p].size(), exp_q[p].size());
    for (int i = 0; i < exp_q[p].size() &&
                    i < got[p].size(); i++)
      check(tag, got[p][i], exp_q[p][i]);
    got[p].delete();
    exp_q[p].delete();
  endtask

  task automatic push_exp(input int a, input bq_t p);
    foreach (p[i]) exp_q[a].push_back(p[i]);
  endtask

  // Fill a port, observe backpressure, then drain
  task automatic full_test(input logic [1:0] a,
                           input int len);
    bq_t p;
    p = make_pkt(a, len, 1'b0);
    push_exp(a, p);
    fork
      send(p);
      begin
        cycles(22);
        check("full_busy", busy, 1);
        check("full_vld", vld_of(a), 1);
        set_rd(3'b001 << a);
      end
    join
    cycles(3);
    drain(a);
    set_rd(3'b000);
    check("full_err", err, 0);
    cmp_port(a, "full_data");
  endtask

  initial begin
    bq_t p, pa, pb;
    logic [7:0] last;
    logic [1:0] a;
    bit bad;

    // Reset state
    do_reset();
    check("rst_busy", busy, 0);
    check("rst_err", err, 0);
    check("rst_vld0", vld_out_0, 0);
    check("rst_vld1", vld_out_1, 0);
    check("rst_vld2", vld_out_2, 0);
    check("rst_dout0", data_out_0, 0);
    check("rst_dout2", data_out_2, 0);

    // Port 0, L=14, good parity, read afterwards
    p = make_pkt(2'd0, 14, 1'b0);
    push_exp(0, p);
    send(p);
    cycles(3);
    check("p0_err", err, 0);
    check("p0_vld", vld_out_0, 1);
    check("p0_busy", busy, 0);
    last = p[p.size() - 1];
    set_rd(3'b001);
    drain(0);
    set_rd(3'b000);
    check("p0_vld_end", vld_out_0, 0);
    check("p0_hold", data_out_0, last);
    cmp_port(0, "p0_data");

    // Same packet, bad parity, never read: flush
    p[p.size() - 1] = ~p[p.size() - 1];
    rise_c = -1;
    fall_c = -1;
    send(p);
    cycles(3);
    check("bad_err", err, 1);
    drain(0);
    check("tmo_len", fall_c - rise_c, TIMEOUT);
    check("tmo_vld", vld_out_0, 0);
    check("tmo_noread", got[0].size(), 0);

    // Invalid address: packet swallowed, err kept
    p = make_pkt(2'd3, 17, 1'b0);
    send(p);
    cycles(3);
    check("inv_err", err, 1);
    check("inv_vld0", vld_out_0, 0);
    check("inv_vld1", vld_out_1, 0);
    check("inv_vld2", vld_out_2, 0);
    check("inv_busy", busy, 0);

    // Backpressure on full FIFO
    full_test(2'd1, 16);
    full_test(2'd2, 17);

    // Stuck full, reset mid-packet
    p = make_pkt(2'd0, 17, 1'b0);
    fork
      send(p);
      begin
        cycles(22);
        check("stuck_busy", busy, 1);
        abort_drv = 1'b1;
      end
    join
    abort_drv = 1'b0;
    do_reset();
    check("mid_busy", busy, 0);
    check("mid_vld0", vld_out_0, 0);
    check("mid_err", err, 0);
    check("mid_dout0", data_out_0, 0);
    p = make_pkt(2'd0, 2, 1'b0);
    push_exp(0, p);
    set_rd(3'b001);
    send(p);
    cycles(3);
    drain(0);
    set_rd(3'b000);
    cmp_port(0, "post_rst");

    // Second packet waits for a read
    pa = make_pkt(2'd2, 3, 1'b0);
    pb = make_pkt(2'd2, 4, 1'b1);
    push_exp(2, pa);
    push_exp(2, pb);
    send(pa);
    fork
      send(pb);
      begin
        cycles(6);
        check("wait_busy", busy, 1);
        set_rd(3'b100);
      end
    join
    cycles(3);
    drain(2);
    set_rd(3'b000);
    check("wait_err", err, 1);
    cmp_port(2, "wait_rd");

    // Second packet waits for a timeout flush
    pa = make_pkt(2'd2, 3, 1'b0);
    pb = make_pkt(2'd2, 4, 1'b0);
    push_exp(2, pb);
    send(pa);
    fork
      send(pb);
      begin
        cycles(6);
        check("wflush_busy", busy, 1);
      end
    join
    cycles(3);
    check("wflush_err", err, 0);
    check("wflush_vld", vld_out_2, 1);
    set_rd(3'b100);
    drain(2);
    set_rd(3'b000);
    cmp_port(2, "wflush");

    // Random packets, all ports read continuously
    exp_err = err;
    set_rd(3'b111);
    for (int k = 0; k < 12; k++) begin
      a = 2'($urandom_range(0, 3));
      bad = 1'($urandom_range(0, 1));
      p = make_pkt(a, $urandom_range(1, 40), bad);
      if (a != 2'd3) begin
        push_exp(a, p);
        exp_err = bad;
      end
      send(p);
      cycles(3);
      check("rnd_err", err, exp_err);
    end
    cycles(4);
    set_rd(3'b000);
    cmp_port(0, "rnd_p0");
    cmp_port(1, "rnd_p1");
    cmp_port(2, "rnd_p2");
    check("rnd_vld0", vld_out_0, 0);
    check("rnd_vld1", vld_out_1, 0);
    check("rnd_vld2", vld_out_2, 0);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/packet_router_1x3.md
Name: packet_router_1x3

Overview:
- Single-input, three-output byte-stream packet router.
- Accepts variable-length packets on one 8-bit input and steers each to one of three output FIFOs based on a 2-bit address in the header byte.
- Checks a trailing XOR parity byte and flags errors.
- Provides per-port valid/read handshakes, with a timeout flush for outputs that are never read.

Parameters:
- FIFO_DEPTH, 16, entries per output FIFO (power of two).
- DATA_W, 8, byte width.
- TIMEOUT, 30, cycles a port may hold valid data unread before it is flushed.

Ports:
- clock  in  1  system clock; all logic on rising edge.
- resetn  in  1  synchronous, active-high reset (1 = reset).
- pkt_valid  in  1  high while header/payload are on data_in; low on the parity byte.
- read_enb_0/1/2  in  1 each  read strobe for output port 0/1/2.
- data_in  in  8  packet byte stream.
- data_out_0/1/2  out  8 each  output port data.
- vld_out_0/1/2  out  1 each  port FIFO not empty.
- err  out  1  parity mismatch on last packet.
- busy  out  1  router cannot accept a new byte this cycle.

Behaviour:
- Packet format:
  - Header byte: [7:2] payload length L (1..63), [1:0] address.
  - Then L payload bytes with pkt_valid=1.
  - Then one parity byte with pkt_valid=0; parity = XOR of header and all payload bytes.
- A byte is sampled at a rising edge only when busy=0; the source holds data while busy=1.
- Reset: FSM to DECODE_ADDRESS, all FIFOs emptied, data_out_x=0, vld_out_x=0, err=0, busy=0, internal registers cleared. Reset mid-packet aborts the packet; nothing partial remains.
- FSM states and transitions:
  - DECODE_ADDRESS (busy=0): on pkt_valid with addr 0..2 → LOAD_FIRST_DATA if the target FIFO is empty, else WAIT_TILL_EMPTY. Addr 3 → stay; byte and its packet are ignored.
  - WAIT_TILL_EMPTY (busy=1): → LOAD_FIRST_DATA when the target FIFO empties.
  - LOAD_FIRST_DATA (busy=1): header (latched at decode) written to FIFO; → LOAD_DATA.
  - LOAD_DATA (busy=0): write data_in each cycle while pkt_valid=1. FIFO full → FIFO_FULL_STATE. pkt_valid=0 → latch parity byte, → LOAD_PARITY.
  - FIFO_FULL_STATE (busy=1): hold until not full → LOAD_AFTER_FULL.
  - LOAD_AFTER_FULL (busy=1): write the held byte. Then → LOAD_DATA if pkt_valid still 1, else → LOAD_PARITY.
  - LOAD_PARITY (busy=1): write parity byte; → CHECK_PARITY_ERROR.
  - CHECK_PARITY_ERROR (busy=1): err ← (computed ≠ received). → DECODE_ADDRESS.
- err holds its value until the next header is accepted or reset.
- Every packet stores L+2 bytes in the FIFO: header, payload, parity.
- FIFO write and read in the same cycle are both allowed. Write while full is dropped; read while empty is ignored.
- Output side:
  - vld_out_x = target FIFO not empty.
  - read_enb_x=1 with data present: data_out_x ← head byte at the next edge; pointer advances.
  - data_out_x holds its last value otherwise.
- Timeout flush: vld_out_x=1 with read_enb_x=0 for TIMEOUT consecutive cycles flushes FIFO x. vld_out_x=0 on the next cycle; the counter clears on any read or when empty. If the FSM is writing port x at that moment, it returns to DECODE_ADDRESS.

Decomposition:
- Shared package: FSM state enum, address constants (PORT0..PORT2, ADDR_INVALID=3), DATA_W, FIFO_DEPTH, TIMEOUT.
- One sub-module, router_fifo, instantiated 3×: synchronous FIFO with full/empty flags, flush input, and the timeout counter.
- FSM, address decode, parity register and busy/err logic live in the top module.

Test Plan:
- Reset, then packet addr 0, L=14, good parity; after it completes assert read_enb_0 → 16 bytes read in order (header 0x38 first), vld_out_0 falls after the last byte, err=0.
- Same packet with inverted parity, never read → err=1 after CHECK_PARITY_ERROR; vld_out_0 falls 30 cycles after going high (flush).
- Packets addr 1 L=16 and addr 2 L=17, no read during write → busy asserts at FIFO full; enabling the read drains the FIFO, the packet completes, and all 19 bytes arrive on port 2.
- Addr 0 L=17 with no read → busy stuck high; resetn pulse → busy=0, vld_out_0=0, FIFO empty.
- Header addr 3 (0x47) L=17 → all vld_out stay 0, no FIFO writes, err unchanged.
- Second packet to port 2 while a prior packet is unread → FSM waits in WAIT_TILL_EMPTY with busy=1 until read or timeout flush.
